// File: rtl/i2c_eeprom_slv.sv
`timescale 1ns/1ps
// I2C EEPROM-style slave: 16-bit address pointer, byte writes, sequential reads with auto-increment.
// Latency: SYNC_STAGES (+2 with glitch filter) clk from bus pins to edge detection; mem_rdata captured 1 clk after mem_re.
// Backpressure: none; the slave never stretches SCL, so clk must run at least 8x the SCL rate.
// Ports: clk/rst_n (async active-low); scl/sda I2C bus (sda open-drain);
//        mem_addr/mem_wdata/mem_we/mem_re/mem_rdata memory side; busy high from START until STOP or NACK-abort.
// Optional: define I2C_SLV_GLITCH_FILTER_EN to add a 3-sample majority filter on each synchronized line.
module i2c_eeprom_slv #(
    parameter logic [6:0] DEV_ADDR    = 7'b1010000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    inout  wire         sda,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, AHI, ACK_AHI, ALO, ACK_ALO, WDAT, ACK_WDAT, RDAT, MACK
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic [SYNC_STAGES+3:0] settle_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic [7:0]             shift_q;
    logic [3:0]             bit_cnt_q;
    logic [15:0]            addr_ptr_q, mem_addr_q;
    logic [7:0]             mem_wdata_q;
    logic                   mem_we_q, mem_re_q, rd_load_q, sda_oe_q;
    logic                   mem_we_d, mem_re_d, sda_oe_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            settle_q   <= '0;
        end else begin
            scl_sync_q <= SYNC_STAGES'({scl_sync_q, scl});
            sda_sync_q <= SYNC_STAGES'({sda_sync_q, sda});
            settle_q   <= (SYNC_STAGES+4)'({settle_q, 1'b1});
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q, sda_hist_q;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
        end else begin
            scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[SYNC_STAGES-1]};
            sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[SYNC_STAGES-1]};
        end
    end

    assign scl_s = maj3(scl_hist_q);
    assign sda_s = maj3(sda_hist_q);
`else
    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

    // The synchronizers come out of reset at 1 while the real bus may be low;
    // bus events stay masked until that reset value has flushed through, so a
    // transfer interrupted by reset is ignored until a genuine START.
    logic armed;
    assign armed = settle_q[SYNC_STAGES+3];

    logic scl_rise, scl_fall, start_det, stop_det, byte_done, addr_match, shifting_in, counting;
    assign scl_rise    = armed & scl_s & ~scl_prev_q;
    assign scl_fall    = armed & ~scl_s & scl_prev_q;
    assign start_det   = armed & scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det    = armed & scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign byte_done   = scl_fall && (bit_cnt_q == 4'd8);
    assign addr_match  = (shift_q[7:1] == DEV_ADDR);
    assign shifting_in = (state_q == DEV) || (state_q == AHI) || (state_q == ALO) || (state_q == WDAT);
    assign counting    = shifting_in || (state_q == RDAT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; protocol states advance on SCL falling edges so the
    // ACK slot is always a full SCL period.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = DEV;
        end else if (stop_det) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                DEV:      if (byte_done) state_d = addr_match ? ACK_DEV : IDLE;
                ACK_DEV:  if (scl_fall)  state_d = shift_q[0] ? RDAT : AHI;
                AHI:      if (byte_done) state_d = ACK_AHI;
                ACK_AHI:  if (scl_fall)  state_d = ALO;
                ALO:      if (byte_done) state_d = ACK_ALO;
                ACK_ALO:  if (scl_fall)  state_d = WDAT;
                WDAT:     if (byte_done) state_d = ACK_WDAT;
                ACK_WDAT: if (scl_fall)  state_d = WDAT;
                RDAT:     if (byte_done) state_d = MACK;
                MACK: begin
                    // Master NACK ends the read immediately; ACK continues on the falling edge.
                    if (scl_rise && sda_s) state_d = IDLE;
                    else if (scl_fall)     state_d = RDAT;
                end
                default:  state_d = state_q;
            endcase
        end
    end

    // Output logic: sda drive and memory strobes, all registered below.
    always_comb begin
        sda_oe_d = sda_oe_q;
        mem_we_d = 1'b0;
        mem_re_d = 1'b0;
        if (start_det || stop_det) begin
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                DEV:      if (byte_done) sda_oe_d = addr_match;
                AHI, ALO: if (byte_done) sda_oe_d = 1'b1;
                WDAT: if (byte_done) begin
                    sda_oe_d = 1'b1;
                    mem_we_d = 1'b1;
                end
                ACK_DEV: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    mem_re_d = shift_q[0];
                end
                ACK_AHI, ACK_ALO, ACK_WDAT: if (scl_fall) sda_oe_d = 1'b0;
                RDAT: begin
                    if (rd_load_q)     sda_oe_d = ~mem_rdata[7];
                    else if (byte_done) sda_oe_d = 1'b0;
                    else if (scl_fall)  sda_oe_d = ~shift_q[6];
                end
                MACK: begin
                    sda_oe_d = 1'b0;
                    if (scl_fall) mem_re_d = 1'b1;
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            addr_ptr_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            rd_load_q   <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            mem_we_q   <= mem_we_d;
            mem_re_q   <= mem_re_d;
            rd_load_q  <= mem_re_q;
            sda_oe_q   <= sda_oe_d;

            // Any state change (or START) restarts the bit count, which also drops partial bytes.
            if (start_det || (state_d != state_q))              bit_cnt_q <= '0;
            else if (scl_rise && counting && bit_cnt_q != 4'd8) bit_cnt_q <= bit_cnt_q + 4'd1;

            if (rd_load_q)
                shift_q <= mem_rdata;
            else if (scl_rise && shifting_in && bit_cnt_q != 4'd8)
                shift_q <= {shift_q[6:0], sda_s};
            else if (scl_fall && state_q == RDAT && bit_cnt_q != 4'd8)
                shift_q <= {shift_q[6:0], 1'b0};

            if (state_q == AHI && byte_done)                 addr_ptr_q[15:8] <= shift_q;
            else if (state_q == ALO && byte_done)            addr_ptr_q[7:0]  <= shift_q;
            else if (state_q == WDAT && byte_done)           addr_ptr_q <= addr_ptr_q + 16'd1;
            else if (state_q == MACK && scl_rise && !sda_s)  addr_ptr_q <= addr_ptr_q + 16'd1;

            if (mem_we_d) begin
                mem_addr_q  <= addr_ptr_q;
                mem_wdata_q <= shift_q;
            end else if (mem_re_d) begin
                mem_addr_q  <= addr_ptr_q;
            end
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/i2c_eeprom_slv.md
I2C_EEPROM_SLV -- requirements
Module: i2c_eeprom_slv

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'b1010000, the 7-bit I2C device address it responds to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on scl and sda.
REQ-003 SHALL have port clk  input  1  system clock; must run at least 8x the SCL rate.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port scl  input  1  I2C clock from the bus master.
REQ-006 SHALL have port sda  inout  1  I2C data; open-drain, driven only to 0, else 1'bz.
REQ-007 SHALL have port mem_addr  output  16  memory word address.
REQ-008 SHALL have port mem_wdata  output  8  write data.
REQ-009 SHALL have port mem_we  output  1  one-clk write strobe.
REQ-010 SHALL have port mem_re  output  1  one-clk read strobe.
REQ-011 SHALL have port mem_rdata  input  8  read data, valid exactly 1 clk after mem_re.
REQ-012 SHALL have port busy  output  1  high from START until STOP or a NACK-abort.

Function
REQ-013 SHALL synchronize scl and sda through SYNC_STAGES flops, then detect edges on the synchronized values.
REQ-014 SHALL detect START (incl. repeated START) as synchronized-sda falling while synchronized-scl is high; from any state it SHALL enter DEV.
REQ-015 SHALL detect STOP as sda rising while scl is high; from any state it SHALL enter IDLE, release sda, and drop busy.
REQ-016 SHALL sample sda on scl rising edges, MSB first, and change its own sda drive only on scl falling edges.
REQ-017 SHALL implement states IDLE, DEV, ACK_DEV, AHI, ACK_AHI, ALO, ACK_ALO, WDAT, ACK_WDAT, RDAT, MACK.
REQ-018 In DEV, after 8 bits, SHALL go to ACK_DEV (drive 0 for one SCL period) if bits[7:1]==DEV_ADDR, else go to IDLE with sda released (NACK).
REQ-019 After ACK_DEV, SHALL go to AHI if R/W=0, or to RDAT if R/W=1, reading from the current address pointer.
REQ-020 SHALL load addr_ptr[15:8] in AHI and addr_ptr[7:0] in ALO, ACKing each byte; after ACK_ALO it SHALL go to WDAT.
REQ-021 In WDAT, after each byte, SHALL pulse mem_we for one clk with mem_addr=addr_ptr, ACK, increment addr_ptr, and stay in WDAT.
REQ-022 Entering RDAT, SHALL pulse mem_re on the ACK-slot falling edge, capture mem_rdata one clk later into the shift register, and shift it out MSB first, driving 0 for data bit 0 and releasing for 1.
REQ-023 After 8 read bits, SHALL release sda and sample the master ACK in MACK; ACK (0) increments addr_ptr and re-enters RDAT, NACK (1) goes to IDLE.
REQ-024 addr_ptr SHALL increment modulo 2^16 (16'hFFFF wraps to 16'h0000) on both write and read.
REQ-025 A repeated START after ALO (random read) SHALL keep addr_ptr.
REQ-026 A START or STOP arriving mid-byte SHALL discard the partial byte with no mem_we.

Reset
REQ-027 On rst_n low, SHALL asynchronously set state=IDLE, sda released, mem_we=0, mem_re=0, busy=0, mem_addr=0, mem_wdata=0, addr_ptr=0, and synchronizers to 1.
REQ-028 Reset asserted mid-transfer SHALL release sda within the same clk; after release, the block SHALL ignore the bus until the next START.

Configuration
REQ-029 With I2C_SLV_GLITCH_FILTER_EN defined, SHALL pass each synchronized line through a 3-sample majority filter, adding 2 clk latency and rejecting pulses <=1 clk.
REQ-030 Without I2C_SLV_GLITCH_FILTER_EN, the synchronized lines SHALL be used directly, with no filtering.

Verification
REQ-031 Write: START, 0xA0, 0x12, 0x34, 0x5A, STOP -> four ACKs; mem_we once with mem_addr=0x1234, mem_wdata=0x5A.
REQ-032 Random read: START, 0xA0, 0x12, 0x34, rSTART, 0xA1, master NACK, STOP -> bus byte equals mem_rdata at 0x1234; busy low after STOP.
REQ-033 Wrong device address: START, 0xA2 -> sda never driven low, no mem strobes, state IDLE.
REQ-034 Sequential read with wrap: pointer at 0xFFFF, read 3 bytes with ACK, ACK, NACK -> mem_re at addresses 0xFFFF, 0x0000, 0x0001.
REQ-035 Abort: STOP after 4 bits of a data byte -> no mem_we, state IDLE; rst_n low mid-RDAT -> sda released immediately.
REQ-036 With the macro defined, a 1-clk low glitch on scl during WDAT -> no extra bit shifted, and the written byte is unchanged.
